// File: rtl/aibcr3_txdrv_seq.sv
// ---------------------------------------------------------------------------
// aibcr3_txdrv_seq
//
// Per-channel control sequencer for the AIB TX pad drivers. Each channel
// ramps its pull-up and pull-down drive-strength codes one step at a time
// when it is enabled, disabled or retargeted, so pad current never changes
// in a single jump. The tristate enable and the weak-pull enables are
// produced alongside the codes.
//
// Parameters
//   NCH      number of TX channels
//   DRVW     drive-code width per direction
//   STEP_CYC clock cycles between code steps
//
// Ports
//   clk             core clock
//   reset           synchronous, active-high reset
//   tx_en           [NCH]       per-channel driver enable request
//   pdrv_tgt        [NCH*DRVW]  target pull-up code, channel i at [i*DRVW +: DRVW]
//   ndrv_tgt        [NCH*DRVW]  target pull-down code, same packing
//   weak_mode       [NCH*2]     weak pull while OFF: 01 pulldown, 10 pullup, else none
//   pdrv_code       [NCH*DRVW]  registered pull-up drive code
//   ndrv_code       [NCH*DRVW]  registered pull-down drive code
//   tristateb       [NCH]       registered driver enable (1 = driving)
//   weak_pullupenb  [NCH]       registered weak pull-up enable, active low
//   weak_pulldownen [NCH]       registered weak pull-down enable, active high
//   drv_ready       [NCH]       channel ON and both codes equal live targets
// ---------------------------------------------------------------------------
module aibcr3_txdrv_seq #(
   parameter int NCH      = 4,
   parameter int DRVW     = 2,
   parameter int STEP_CYC = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCH-1:0]      tx_en,
   input  logic [NCH*DRVW-1:0] pdrv_tgt,
   input  logic [NCH*DRVW-1:0] ndrv_tgt,
   input  logic [NCH*2-1:0]    weak_mode,
   output logic [NCH*DRVW-1:0] pdrv_code,
   output logic [NCH*DRVW-1:0] ndrv_code,
   output logic [NCH-1:0]      tristateb,
   output logic [NCH-1:0]      weak_pullupenb,
   output logic [NCH-1:0]      weak_pulldownen,
   output logic [NCH-1:0]      drv_ready
);

   localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(STEP_CYC - 1);

   typedef enum logic [1:0] {
      S_OFF     = 2'd0,
      S_RAMP_UP = 2'd1,
      S_ON      = 2'd2,
      S_RAMP_DN = 2'd3
   } state_t;

   // One code step toward the target; holds once equal, so it never overshoots.
   function automatic logic [DRVW-1:0] step_toward(input logic [DRVW-1:0] cur,
                                                   input logic [DRVW-1:0] tgt);
      logic [DRVW-1:0] res;
      res = cur;
      if (cur < tgt)
         res = cur + DRVW'(1);
      else if (cur > tgt)
         res = cur - DRVW'(1);
      return res;
   endfunction

   // One code step toward zero; zero stays zero.
   function automatic logic [DRVW-1:0] step_down(input logic [DRVW-1:0] cur);
      logic [DRVW-1:0] res;
      res = cur;
      if (cur != '0)
         res = cur - DRVW'(1);
      return res;
   endfunction

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_t          state, state_nxt;
      logic [TW-1:0]   timer, timer_nxt;
      logic [DRVW-1:0] pcode, pcode_nxt;
      logic [DRVW-1:0] ncode, ncode_nxt;
      logic            tri_q, tri_nxt;
      logic            pu_enb_q, pu_enb_nxt;
      logic            pd_en_q, pd_en_nxt;
      logic [DRVW-1:0] ptgt, ntgt;
      logic [1:0]      mode;
      logic            en;
      logic            tick;

      assign ptgt = pdrv_tgt[g*DRVW +: DRVW];
      assign ntgt = ndrv_tgt[g*DRVW +: DRVW];
      assign mode = weak_mode[g*2 +: 2];
      assign en   = tx_en[g];
      assign tick = (timer == '0);

      always_comb begin
         state_nxt = state;
         // Free-running step timer; every state change below reloads it.
         timer_nxt = tick ? RELOAD : (timer - TW'(1));
         pcode_nxt = pcode;
         ncode_nxt = ncode;

         case (state)
            S_OFF: begin
               timer_nxt = RELOAD;
               pcode_nxt = '0;
               ncode_nxt = '0;
               if (en)
                  state_nxt = S_RAMP_UP;
            end
            S_RAMP_UP: begin
               if (!en) begin
                  state_nxt = S_RAMP_DN;
                  timer_nxt = RELOAD;
               end else if (tick) begin
                  pcode_nxt = step_toward(pcode, ptgt);
                  ncode_nxt = step_toward(ncode, ntgt);
                  if ((pcode_nxt == ptgt) && (ncode_nxt == ntgt))
                     state_nxt = S_ON;
               end
            end
            S_ON: begin
               if (!en) begin
                  state_nxt = S_RAMP_DN;
                  timer_nxt = RELOAD;
               end else if (tick) begin
                  pcode_nxt = step_toward(pcode, ptgt);
                  ncode_nxt = step_toward(ncode, ntgt);
               end
            end
            S_RAMP_DN: begin
               // Reversal keeps the current codes and ramps up from there.
               if (en) begin
                  state_nxt = S_RAMP_UP;
                  timer_nxt = RELOAD;
               end else if (tick) begin
                  pcode_nxt = step_down(pcode);
                  ncode_nxt = step_down(ncode);
                  if ((pcode_nxt == '0) && (ncode_nxt == '0))
                     state_nxt = S_OFF;
               end
            end
            default: begin
               state_nxt = S_OFF;
               timer_nxt = RELOAD;
               pcode_nxt = '0;
               ncode_nxt = '0;
            end
         endcase

         // Pad controls are registered from the next state so they switch on
         // the same edge as the state itself.
         tri_nxt    = (state_nxt != S_OFF);
         pu_enb_nxt = 1'b1;
         pd_en_nxt  = 1'b0;
         if (state_nxt == S_OFF) begin
            pu_enb_nxt = (mode != 2'b10);
            pd_en_nxt  = (mode == 2'b01);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state    <= S_OFF;
            timer    <= RELOAD;
            pcode    <= '0;
            ncode    <= '0;
            tri_q    <= 1'b0;
            pu_enb_q <= 1'b1;
            pd_en_q  <= 1'b0;
         end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            pcode    <= pcode_nxt;
            ncode    <= ncode_nxt;
            tri_q    <= tri_nxt;
            pu_enb_q <= pu_enb_nxt;
            pd_en_q  <= pd_en_nxt;
         end
      end

      assign pdrv_code[g*DRVW +: DRVW] = pcode;
      assign ndrv_code[g*DRVW +: DRVW] = ncode;
      assign tristateb[g]              = tri_q;
      assign weak_pullupenb[g]         = pu_enb_q;
      assign weak_pulldownen[g]        = pd_en_q;
      assign drv_ready[g] = (state == S_ON) && (pcode == ptgt) && (ncode == ntgt);
   end

endmodule

// File: tb/tb_aibcr3_txdrv_seq.sv
// ---------------------------------------------------------------------------
// tb_aibcr3_txdrv_seq
//
// Directed bench for aibcr3_txdrv_seq (NCH=4, DRVW=2, STEP_CYC=4). Inputs
// change 1 time unit after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_aibcr3_txdrv_seq;

   localparam int NCH      = 4;
   localparam int DRVW     = 2;
   localparam int STEP_CYC = 4;

   logic                clk;
   logic                reset;
   logic [NCH-1:0]      tx_en;
   logic [NCH*DRVW-1:0] pdrv_tgt;
   logic [NCH*DRVW-1:0] ndrv_tgt;
   logic [NCH*2-1:0]    weak_mode;
   logic [NCH*DRVW-1:0] pdrv_code;
   logic [NCH*DRVW-1:0] ndrv_code;
   logic [NCH-1:0]      tristateb;
   logic [NCH-1:0]      weak_pullupenb;
   logic [NCH-1:0]      weak_pulldownen;
   logic [NCH-1:0]      drv_ready;

   int total = 0;
   int bad   = 0;

   aibcr3_txdrv_seq #(
      .NCH      (NCH),
      .DRVW     (DRVW),
      .STEP_CYC (STEP_CYC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .tx_en           (tx_en),
      .pdrv_tgt        (pdrv_tgt),
      .ndrv_tgt        (ndrv_tgt),
      .weak_mode       (weak_mode),
      .pdrv_code       (pdrv_code),
      .ndrv_code       (ndrv_code),
      .tristateb       (tristateb),
      .weak_pullupenb  (weak_pullupenb),
      .weak_pulldownen (weak_pulldownen),
      .drv_ready       (drv_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // ch3=11 none, ch2=00 none, ch1=01 pulldown, ch0=10 pullup
      reset     = 1'b1;
      tx_en     = '0;
      pdrv_tgt  = '0;
      ndrv_tgt  = '0;
      weak_mode = 8'b11_00_01_10;
      step(2);

      // ---------------- reset state ----------------
      check("rst_pcode", 32'(pdrv_code), 32'h00);
      check("rst_ncode", 32'(ndrv_code), 32'h00);
      check("rst_tri",   32'(tristateb), 32'h0);
      check("rst_puenb", 32'(weak_pullupenb), 32'hF);
      check("rst_pden",  32'(weak_pulldownen), 32'h0);
      check("rst_rdy",   32'(drv_ready), 32'h0);

      reset = 1'b0;
      step(1);
      check("rel_puenb", 32'(weak_pullupenb), 32'hE);
      check("rel_pden",  32'(weak_pulldownen), 32'h2);

      // ---------------- ramp up ch0 to 3/2 ----------------
      pdrv_tgt[1:0] = 2'd3;
      ndrv_tgt[1:0] = 2'd2;
      tx_en[0]      = 1'b1;
      step(1); // edge E
      check("up_tri",   32'(tristateb), 32'h1);
      check("up_puenb", 32'(weak_pullupenb), 32'hF);
      check("up_p0",    32'(pdrv_code[1:0]), 32'd0);
      step(3);
      check("up_hold_e3", 32'(pdrv_code[1:0]), 32'd0);
      step(1);
      check("up_p_e4", 32'(pdrv_code[1:0]), 32'd1);
      check("up_n_e4", 32'(ndrv_code[1:0]), 32'd1);
      step(4);
      check("up_p_e8", 32'(pdrv_code[1:0]), 32'd2);
      check("up_n_e8", 32'(ndrv_code[1:0]), 32'd2);
      step(3);
      check("up_rdy_e11", 32'(drv_ready[0]), 32'd0);
      step(1);
      check("up_p_e12",   32'(pdrv_code[1:0]), 32'd3);
      check("up_n_e12",   32'(ndrv_code[1:0]), 32'd2);
      check("up_rdy_e12", 32'(drv_ready[0]), 32'd1);

      // ---------------- ch1 up to 3/3 then ramp down ----------------
      pdrv_tgt[3:2] = 2'd3;
      ndrv_tgt[3:2] = 2'd3;
      tx_en[1]      = 1'b1;
      step(13);
      check("dn_on_rdy", 32'(drv_ready), 32'h3);
      tx_en[1] = 1'b0;
      step(1);
      check("dn_tri_e",  32'(tristateb[1]), 32'd1);
      check("dn_code_e", 32'(pdrv_code[3:2]), 32'd3);
      step(4);
      check("dn_p_4", 32'(pdrv_code[3:2]), 32'd2);
      check("dn_n_4", 32'(ndrv_code[3:2]), 32'd2);
      step(4);
      check("dn_p_8", 32'(pdrv_code[3:2]), 32'd1);
      step(3);
      check("dn_tri_11", 32'(tristateb[1]), 32'd1);
      check("dn_pd_11",  32'(weak_pulldownen[1]), 32'd0);
      step(1);
      check("dn_p_12",   32'(pdrv_code[3:2]), 32'd0);
      check("dn_n_12",   32'(ndrv_code[3:2]), 32'd0);
      check("dn_tri_12", 32'(tristateb[1]), 32'd0);
      check("dn_pd_12",  32'(weak_pulldownen[1]), 32'd1);
      check("dn_ch0_rdy", 32'(drv_ready[0]), 32'd1);

      // ---------------- ch2 reversal ----------------
      pdrv_tgt[5:4] = 2'd3;
      ndrv_tgt[5:4] = 2'd3;
      tx_en[2]      = 1'b1;
      step(9); // E+8
      check("rev_code_8", 32'(pdrv_code[5:4]), 32'd2);
      tx_en[2] = 1'b0;
      step(2);
      tx_en[2] = 1'b1;
      step(1); // re-raise edge
      check("rev_hold",   32'(pdrv_code[5:4]), 32'd2);
      check("rev_tri",    32'(tristateb[2]), 32'd1);
      step(3);
      check("rev_hold_3", 32'(pdrv_code[5:4]), 32'd2);
      step(1);
      check("rev_p_4",   32'(pdrv_code[5:4]), 32'd3);
      check("rev_n_4",   32'(ndrv_code[5:4]), 32'd3);
      check("rev_rdy_4", 32'(drv_ready[2]), 32'd1);

      // ---------------- ch3 retarget in ON ----------------
      pdrv_tgt[7:6] = 2'd3;
      ndrv_tgt[7:6] = 2'd3;
      tx_en[3]      = 1'b1;
      step(13); // E+12, just entered ON
      check("rt_rdy_on", 32'(drv_ready[3]), 32'd1);
      pdrv_tgt[7:6] = 2'd1;
      #1;
      check("rt_rdy_drop", 32'(drv_ready[3]), 32'd0);
      step(4);
      check("rt_p_1st",   32'(pdrv_code[7:6]), 32'd2);
      check("rt_n_1st",   32'(ndrv_code[7:6]), 32'd3);
      check("rt_rdy_1st", 32'(drv_ready[3]), 32'd0);
      step(4);
      check("rt_p_2nd",   32'(pdrv_code[7:6]), 32'd1);
      check("rt_rdy_2nd", 32'(drv_ready[3]), 32'd1);

      // ---------------- staggered ramps, reset mid-ramp ----------------
      reset = 1'b1;
      tx_en = '0;
      step(1);
      check("rr_off_code", 32'(pdrv_code), 32'h00);
      pdrv_tgt = 8'hFF;
      ndrv_tgt = 8'hFF;
      reset    = 1'b0;
      tx_en    = 4'b0001;
      step(1);
      tx_en = 4'b0011;
      step(1);
      tx_en = 4'b0111;
      step(1);
      tx_en = 4'b1111;
      step(1); // E3
      step(5); // E8: ch0 ticked twice, ch1..ch3 once
      check("st_pcode", 32'(pdrv_code), 32'h56);
      check("st_ncode", 32'(ndrv_code), 32'h56);
      check("st_tri",   32'(tristateb), 32'hF);
      check("st_rdy",   32'(drv_ready), 32'h0);
      reset = 1'b1;
      step(1);
      check("mr_pcode", 32'(pdrv_code), 32'h00);
      check("mr_ncode", 32'(ndrv_code), 32'h00);
      check("mr_tri",   32'(tristateb), 32'h0);
      check("mr_puenb", 32'(weak_pullupenb), 32'hF);
      check("mr_pden",  32'(weak_pulldownen), 32'h0);
      check("mr_rdy",   32'(drv_ready), 32'h0);
      reset = 1'b0;
      tx_en = '0;
      step(1);
      check("mr_rel_puenb", 32'(weak_pullupenb), 32'hE);
      check("mr_rel_pden",  32'(weak_pulldownen), 32'h2);

      // ---------------- zero targets on ch1 ----------------
      pdrv_tgt = '0;
      ndrv_tgt = '0;
      tx_en[1] = 1'b1;
      step(1);
      check("z_tri",   32'(tristateb[1]), 32'd1);
      check("z_pden",  32'(weak_pulldownen[1]), 32'd0);
      step(3);
      check("z_rdy_3", 32'(drv_ready[1]), 32'd0);
      step(1);
      check("z_rdy_4",  32'(drv_ready[1]), 32'd1);
      check("z_code_4", 32'(pdrv_code), 32'h00);
      tx_en[1] = 1'b0;
      step(1);
      check("z_dn_tri_e", 32'(tristateb[1]), 32'd1);
      step(3);
      check("z_dn_tri_3", 32'(tristateb[1]), 32'd1);
      step(1);
      check("z_dn_tri_4", 32'(tristateb[1]), 32'd0);
      check("z_dn_pd_4",  32'(weak_pulldownen[1]), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
